// File: rtl/reg_hazard_unit.sv
// reg_hazard_unit: ID-stage operand resolver and interlock.
//   Resolves NUM_RPORTS register read operands against NUM_FWD in-flight
//   pipeline stages (index 0 youngest) and a long-latency completion bus.
//   Raises stall_o for non-ready forwarding sources and, when built with
//   REG_HAZARD_SCOREBOARD_EN, for registers pending in a long-latency
//   scoreboard plus a WAW interlock on re-issue to a pending register.
//   Without the macro there are no scoreboard flops and pending_o reads 0.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   rden_i/raddr_i/rdata_i     per-port read enable, address, regfile data
//   fwd_we_i/waddr/wdata/ready per-stage forwarding sources
//   issue_valid/long/waddr_i   instruction leaving ID
//   cpl_valid/waddr/wdata_i    long-latency write-back bus
//   flush_i                    kills all pending long-latency operations
//   rdata_o, stall_o           resolved operands, ID/IF hold (combinational)
//   pending_o                  scoreboard state (debug)
//   stall_cnt_o                saturating stalled-cycle count
module reg_hazard_unit #(
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_FWD    = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RPORTS-1:0]        rden_i,
  input  logic [NUM_RPORTS*ADDR_W-1:0] raddr_i,
  input  logic [NUM_RPORTS*DATA_W-1:0] rdata_i,
  input  logic [NUM_FWD-1:0]           fwd_we_i,
  input  logic [NUM_FWD*ADDR_W-1:0]    fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0]    fwd_wdata_i,
  input  logic [NUM_FWD-1:0]           fwd_ready_i,
  input  logic                         issue_valid_i,
  input  logic                         issue_long_i,
  input  logic [ADDR_W-1:0]            issue_waddr_i,
  input  logic                         cpl_valid_i,
  input  logic [ADDR_W-1:0]            cpl_waddr_i,
  input  logic [DATA_W-1:0]            cpl_wdata_i,
  input  logic                         flush_i,
  output logic [NUM_RPORTS*DATA_W-1:0] rdata_o,
  output logic                         stall_o,
  output logic [(2**ADDR_W)-1:0]       pending_o,
  output logic [15:0]                  stall_cnt_o
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam int unsigned CNT_W    = 16;

  logic [NUM_RPORTS-1:0] port_haz_c;
  logic                  waw_c;
  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;

`ifdef REG_HAZARD_SCOREBOARD_EN
  logic [NUM_REGS-1:0]   pending_d, pending_q;
`endif

  // Per-port operand resolution; first matching rule wins.
  always_comb begin : resolve
    logic [ADDR_W-1:0] addr;
    logic              hit;
    addr       = '0;
    hit        = 1'b0;
    rdata_o    = '0;
    port_haz_c = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      addr = raddr_i[p*ADDR_W +: ADDR_W];
      hit  = 1'b0;
      if (addr != '0) begin
        // Youngest matching stage shadows all older ones, ready or not.
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!hit && fwd_we_i[k] && (fwd_waddr_i[k*ADDR_W +: ADDR_W] == addr)) begin
            hit = 1'b1;
            if (fwd_ready_i[k]) begin
              rdata_o[p*DATA_W +: DATA_W] = fwd_wdata_i[k*DATA_W +: DATA_W];
            end else begin
              port_haz_c[p] = 1'b1;
            end
          end
        end
        if (!hit) begin
          if (cpl_valid_i && (cpl_waddr_i == addr)) begin
            rdata_o[p*DATA_W +: DATA_W] = cpl_wdata_i;
          end else begin
            rdata_o[p*DATA_W +: DATA_W] = rdata_i[p*DATA_W +: DATA_W];
`ifdef REG_HAZARD_SCOREBOARD_EN
            if (pending_q[addr]) begin
              port_haz_c[p] = 1'b1;
            end
`endif
          end
        end
      end
    end
    if (rst_i) begin
      rdata_o    = '0;
      port_haz_c = '0;
    end
  end

  // WAW interlock: re-issue of a long op to a still-pending destination.
`ifdef REG_HAZARD_SCOREBOARD_EN
  assign waw_c = issue_valid_i && issue_long_i && (issue_waddr_i != '0) &&
                 pending_q[issue_waddr_i] &&
                 !(cpl_valid_i && (cpl_waddr_i == issue_waddr_i));
`else
  logic unused_sb_c;
  assign unused_sb_c = ^{issue_valid_i, issue_long_i, issue_waddr_i, flush_i};
  assign waw_c       = 1'b0;
`endif

  assign stall_o = !rst_i && ((|(port_haz_c & rden_i)) || waw_c);

  // Scoreboard next state: clear, then set (younger issue wins), then flush.
`ifdef REG_HAZARD_SCOREBOARD_EN
  always_comb begin : sb_next
    pending_d = pending_q;
    if (cpl_valid_i) begin
      pending_d[cpl_waddr_i] = 1'b0;
    end
    if (issue_valid_i && issue_long_i && !stall_o && (issue_waddr_i != '0)) begin
      pending_d[issue_waddr_i] = 1'b1;
    end
    if (flush_i) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin : sb_reg
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
`else
  assign pending_o = '0;
`endif

  // Saturating stalled-cycle counter; flush does not clear it.
  always_comb begin : cnt_next
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin : cnt_reg
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/reg_hazard_unit.md
# reg_hazard_unit

Parametrised successor to the ID-stage RAW forwarding mux. It resolves read operands for `NUM_RPORTS` register read ports against `NUM_FWD` in-flight pipeline stages and a same-cycle completion bus. It adds load-use and long-latency interlock through a per-register pending scoreboard, and a saturating stall-cycle counter. It sits in ID between the register file read ports and the ID/EX pipeline register.

## Interface

- `NUM_RPORTS`, 2: number of operand read ports.
- `NUM_FWD`, 2: number of forwarding stages; index 0 is the youngest (EX), then MEM, and so on.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register address width; register 0 is hardwired zero.
- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `rden_i`  in  NUM_RPORTS: port p actually consumes its operand this cycle.
- `raddr_i`  in  NUM_RPORTS*ADDR_W: port p address, packed at `[p*ADDR_W +: ADDR_W]`.
- `rdata_i`  in  NUM_RPORTS*DATA_W: register-file read data per port.
- `fwd_we_i`  in  NUM_FWD: stage k will write a register.
- `fwd_waddr_i`  in  NUM_FWD*ADDR_W: stage k destination.
- `fwd_wdata_i`  in  NUM_FWD*DATA_W: stage k result.
- `fwd_ready_i`  in  NUM_FWD: stage k result is valid now (0 for a load in EX).
- `issue_valid_i`  in  1: the ID instruction leaves ID this cycle if `stall_o`=0.
- `issue_long_i`  in  1: that instruction is long-latency (divider, multi-cycle load).
- `issue_waddr_i`  in  ADDR_W: its destination.
- `cpl_valid_i`, `cpl_waddr_i`, `cpl_wdata_i`  in  1/ADDR_W/DATA_W: long-latency completion (write-back) bus.
- `flush_i`  in  1: pipeline flush; kills all in-flight long-latency operations.
- `rdata_o`  out  NUM_RPORTS*DATA_W: resolved operands.
- `stall_o`  out  1: hold ID/IF this cycle.
- `pending_o`  out  2**ADDR_W: scoreboard state, for debug.
- `stall_cnt_o`  out  16: saturating count of stalled cycles.

## Operation

- Per-port resolution is combinational. The first matching rule applies:
  1. `rst_i`=1 → operand 0.
  2. Address 0 → operand 0, never stalls.
  3. Youngest stage k with `fwd_we_i[k]` and matching `fwd_waddr_i[k]`: if `fwd_ready_i[k]`, forward `fwd_wdata_i[k]`; otherwise raise a port hazard and output 0. Older stages are ignored once a younger stage matches.
  4. `cpl_valid_i` with matching `cpl_waddr_i` → `cpl_wdata_i` (same-cycle bypass, no stall).
  5. `pending[addr]`=1 → port hazard, operand `rdata_i`.
  6. Otherwise → `rdata_i`.
- A port hazard counts toward stall only when `rden_i[p]`=1.
- WAW interlock: `issue_valid_i & issue_long_i & pending[issue_waddr_i]` (with `issue_waddr_i`≠0) also raises the stall, unless `cpl_valid_i` clears that same register this cycle.
- `stall_o` = OR of all qualified port hazards and the WAW interlock; it is forced to 0 during reset.
- Scoreboard update, evaluated per register each edge, in this priority:
  1. `rst_i` or `flush_i` → all pending bits 0. Flush wins over a same-cycle issue.
  2. Set when `issue_valid_i & issue_long_i & ~stall_o` and `issue_waddr_i`≠0.
  3. Clear when `cpl_valid_i` matches.
  4. Set and clear on the same register in the same cycle → the bit ends at 1. The new issue is younger.
- `pending[0]` is always 0.
- A completion for a register that is not pending is ignored, apart from the bypass in rule 4.
- `stall_cnt_o` increments on each cycle with `stall_o`=1 and saturates at 0xFFFF. Reset clears it; flush does not.

## Timing

- `rdata_o` and `stall_o`: zero-cycle combinational paths from all inputs and from the registered scoreboard.
- Scoreboard latency: a set or clear is visible in operand resolution the cycle after the edge that performs it.
- Minimum pending-bit lifetime is 1 cycle; issue and completion in consecutive cycles works.
- Reset values: `rdata_o`=0, `stall_o`=0, `pending_o`=0, `stall_cnt_o`=0.
- Reset asserted mid-stall: the next cycle shows an empty scoreboard and no stall. Any completion arriving in the reset cycle is dropped.
- The upstream holds `issue_*` stable while `stall_o`=1; no issue is recorded during a stall.

## Configuration

- `REG_HAZARD_SCOREBOARD_EN` defined: scoreboard, WAW interlock, and rule 5 are active as described.
- Undefined: no scoreboard flops.
  - `pending_o` is tied to 0; rule 5 and the WAW interlock are removed.
  - Stalls come only from non-ready forwarding stages.
  - Completion bypass (rule 4) is kept.
  - `stall_cnt_o` is still present.

## Test plan

- Stage 0 writes r3=0x11, stage 1 writes r3=0x22, port 0 reads r3 → 0x11, `stall_o`=0. Repeat with stage 0 `we`=0 → 0x22.
- Load in EX to r5 with `fwd_ready_i[0]`=0; port 1 reads r5 with `rden`=1 → `stall_o`=1. With `rden`=0 → `stall_o`=0. Flip ready to 1 with data 0xAB → 0xAB, no stall.
- Issue long op to r7; next 3 cycles read r7 → stall, `stall_cnt_o` reaches 3. Completion r7=0xDEAD in cycle 4 → 0xDEAD same cycle, no stall; `pending_o[7]`=0 afterwards.
- Pending r7, issue another long op to r7 → WAW stall. Same cycle as completion of r7 → no stall, and `pending_o[7]`=1 after the edge.
- Pending r4 and r9 with `flush_i`=1 and simultaneous long issue to r2 → `pending_o`=0 after the edge. Read of r0 while stage 0 writes r0=0x5 → 0, no stall.
- Macro undefined: long issue to r7 then read r7 → no stall, `rdata_i` passed through. Assert `rst_i` mid-stall → all outputs 0 on the next cycle.
